// File: rtl/eth_pkg.sv
// Shared Ethernet constants and types for the RX frame check and TX encapsulation stages.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  localparam int LEN_CRC  = 4;
  localparam int LEN_ADDR = 6;
  localparam int LEN_LEN  = 2;

  typedef enum logic {
    IDLE,
    RUN
  } rxState_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// One-byte step of the reflected CRC-32 (LSB first); purely combinational.
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC32_POLY) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// Receive FCS check: CRC-32 over the whole frame, strips the trailing FCS bytes
// through a 4-byte delay line and reports CRC/length status at end of frame.
module eth_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic        in_eof,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        frame_done,
  output logic        crc_err,
  output logic        len_err,
  output logic [10:0] frame_len
);

  localparam logic [10:0] LEN_SAT = 11'h7FF;
  localparam logic [10:0] LEN_MIN = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] LEN_MAX = 11'(MAX_FRAME_LEN);
  localparam logic [10:0] FWD_AT  = 11'(LEN_CRC);

  rxState_t    r_state;
  logic [31:0] r_crc;
  logic [10:0] r_count;
  logic [31:0] r_dly;

  logic [31:0] w_crcSeed;
  logic [31:0] w_crcNext;
  logic [10:0] w_countInc;

  // A start-of-frame byte always folds into a fresh CRC, even mid-frame.
  assign w_crcSeed  = in_sof ? CRC32_INIT : r_crc;
  assign w_countInc = (r_count == LEN_SAT) ? r_count : r_count + 11'd1;

  eth_crc32_byte u_crc (
    .crc_in  (w_crcSeed),
    .data    (in_data),
    .crc_out (w_crcNext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_crc      <= CRC32_INIT;
      r_count    <= 11'd0;
      r_dly      <= 32'h0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
      crc_err    <= 1'b0;
      len_err    <= 1'b0;
      frame_len  <= 11'd0;
    end else begin
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid && in_sof) begin
        // A new sof inside a frame closes the old one as truncated.
        if (r_state == RUN) begin
          frame_done <= 1'b1;
          crc_err    <= 1'b1;
          len_err    <= 1'b1;
          frame_len  <= r_count;
        end else if (in_eof) begin
          frame_done <= 1'b1;
          crc_err    <= 1'b1;
          len_err    <= 1'b1;
          frame_len  <= 11'd1;
        end
        r_crc   <= w_crcNext;
        r_count <= 11'd1;
        r_dly   <= {24'h000000, in_data};
        r_state <= in_eof ? IDLE : RUN;
      end else if (in_valid && r_state == RUN) begin
        r_crc   <= w_crcNext;
        r_count <= w_countInc;
        r_dly   <= {r_dly[23:0], in_data};
        if (r_count >= FWD_AT) begin
          out_valid <= 1'b1;
          out_data  <= r_dly[31:24];
          out_sof   <= (r_count == FWD_AT);
          out_eof   <= in_eof;
        end
        if (in_eof) begin
          frame_done <= 1'b1;
          crc_err    <= (w_crcNext != CRC32_RESIDUE);
          len_err    <= (w_countInc < LEN_MIN) || (w_countInc > LEN_MAX);
          frame_len  <= w_countInc;
          r_state    <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check: table of frame vectors plus truncation and reset sequences.
module tb_eth_rx_fcs_check;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic        in_eof = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic        frame_done;
  logic        crc_err;
  logic        len_err;
  logic [10:0] frame_len;

  int checks = 0;
  int errors = 0;
  int stepIdx = 0;
  int eofStep = 0;
  int firstStep = 0;

  logic [7:0] txQ[$];
  logic [7:0] expQ[$];
  logic [7:0] rxQ[$];
  int         sofIdx[$];
  int         eofIdx[$];
  int         doneStep[$];
  int         doneCrc[$];
  int         doneLenErr[$];
  int         doneFl[$];

  typedef struct {
    string name;
    int    len;
    int    flip;
    bit    gaps;
    bit    chkCrc;
    bit    expCrcErr;
    bit    expLenErr;
    int    expFl;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  eth_rx_fcs_check dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_eof     (in_eof),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .frame_done (frame_done),
    .crc_err    (crc_err),
    .len_err    (len_err),
    .frame_len  (frame_len)
  );

  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h000000, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sampleOutputs();
    if (out_valid) begin
      if (out_sof) sofIdx.push_back(rxQ.size());
      if (out_eof) eofIdx.push_back(rxQ.size());
      rxQ.push_back(out_data);
    end
    if (frame_done) begin
      doneStep.push_back(stepIdx);
      doneCrc.push_back(int'(crc_err));
      doneLenErr.push_back(int'(len_err));
      doneFl.push_back(int'(frame_len));
    end
  endtask

  task automatic stepCycle(input bit v, input logic [7:0] d, input bit s, input bit e);
    @(negedge clk);
    stepIdx++;
    sampleOutputs();
    in_valid = v;
    in_data  = d;
    in_sof   = s;
    in_eof   = e;
  endtask

  task automatic idle(input int n);
    repeat (n) stepCycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic clearMon();
    rxQ.delete();
    sofIdx.delete();
    eofIdx.delete();
    doneStep.delete();
    doneCrc.delete();
    doneLenErr.delete();
    doneFl.delete();
  endtask

  // Payload (base+i) followed by the FCS, transmitted low byte first.
  task automatic buildFrame(input int len, input int base, input int flip);
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [7:0]  b;
    txQ.delete();
    expQ.delete();
    if (len <= 4) begin
      for (int i = 0; i < len; i++) txQ.push_back(8'hA0 + 8'(i));
    end else begin
      crc = 32'hFFFFFFFF;
      for (int i = 0; i < len - 4; i++) begin
        b = 8'((base + i) & 255);
        txQ.push_back(b);
        expQ.push_back(b);
        crc = crcByte(crc, b);
      end
      fcs = ~crc;
      txQ.push_back(fcs[7:0]);
      txQ.push_back(fcs[15:8]);
      txQ.push_back(fcs[23:16]);
      txQ.push_back(fcs[31:24]);
      if (flip >= 0) begin
        txQ[flip]  = txQ[flip] ^ 8'h01;
        expQ[flip] = expQ[flip] ^ 8'h01;
      end
    end
  endtask

  task automatic sendFrame(input bit gaps, input int nBytes, input bit withEof);
    for (int i = 0; i < nBytes; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) stepCycle(1'b0, 8'h00, 1'b0, 1'b0);
      end
      stepCycle(1'b1, txQ[i], i == 0, withEof && (i == nBytes - 1));
      if (i == 0) firstStep = stepIdx;
      if (i == nBytes - 1) eofStep = stepIdx;
    end
  endtask

  task automatic checkFrame(input string name, input bit chkCrc, input bit expCrcErr,
                            input bit expLenErr, input int expFl);
    int bad;
    int n;
    checkVal({name, " done_count"}, doneStep.size(), 1);
    if (doneStep.size() >= 1) begin
      checkVal({name, " done_timing"}, doneStep[0], eofStep + 1);
      if (chkCrc) checkVal({name, " crc_err"}, doneCrc[0], int'(expCrcErr));
      checkVal({name, " len_err"}, doneLenErr[0], int'(expLenErr));
      checkVal({name, " frame_len"}, doneFl[0], expFl);
    end
    checkVal({name, " out_count"}, rxQ.size(), expQ.size());
    n = (rxQ.size() < expQ.size()) ? rxQ.size() : expQ.size();
    bad = 0;
    for (int i = 0; i < n; i++) if (rxQ[i] !== expQ[i]) bad++;
    checkVal({name, " out_data_errs"}, bad, 0);
    checkVal({name, " sof_count"}, sofIdx.size(), int'(expQ.size() > 0));
    checkVal({name, " eof_count"}, eofIdx.size(), int'(expQ.size() > 0));
    if (expQ.size() > 0 && sofIdx.size() > 0) checkVal({name, " sof_pos"}, sofIdx[0], 0);
    if (expQ.size() > 0 && eofIdx.size() > 0) checkVal({name, " eof_pos"}, eofIdx[0], expQ.size() - 1);
  endtask

  function automatic int outBus();
    return int'({out_data, out_valid, out_sof, out_eof, frame_done, crc_err, len_err, frame_len});
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{"good64",     64,   -1, 1'b0, 1'b1, 1'b0, 1'b0, 64};
    vecs[1]  = '{"flip64",     64,   10, 1'b0, 1'b1, 1'b1, 1'b0, 64};
    vecs[2]  = '{"gaps64",     64,   -1, 1'b1, 1'b1, 1'b0, 1'b0, 64};
    vecs[3]  = '{"short3",     3,    -1, 1'b0, 1'b0, 1'b0, 1'b1, 3};
    vecs[4]  = '{"single1",    1,    -1, 1'b0, 1'b1, 1'b1, 1'b1, 1};
    vecs[5]  = '{"min5",       5,    -1, 1'b0, 1'b1, 1'b0, 1'b1, 5};
    vecs[6]  = '{"under63",    63,   -1, 1'b0, 1'b1, 1'b0, 1'b1, 63};
    vecs[7]  = '{"len65",      65,   -1, 1'b0, 1'b1, 1'b0, 1'b0, 65};
    vecs[8]  = '{"max1518",    1518, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1518};
    vecs[9]  = '{"over1519",   1519, -1, 1'b0, 1'b1, 1'b0, 1'b1, 1519};
    vecs[10] = '{"sat2100",    2100, -1, 1'b0, 1'b1, 1'b0, 1'b1, 2047};

    repeat (3) @(negedge clk);
    checkVal("reset_outputs", outBus(), 0);
    rst = 1'b1;
    idle(2);

    for (int v = 0; v < 11; v++) begin
      clearMon();
      buildFrame(vecs[v].len, 0, vecs[v].flip);
      sendFrame(vecs[v].gaps, txQ.size(), 1'b1);
      idle(3);
      checkFrame(vecs[v].name, vecs[v].chkCrc, vecs[v].expCrcErr, vecs[v].expLenErr, vecs[v].expFl);
    end

    // Classic check string "123456789" whose CRC-32 is 0xCBF43926.
    clearMon();
    txQ.delete();
    expQ.delete();
    for (int i = 0; i < 9; i++) begin
      txQ.push_back(8'h31 + 8'(i));
      expQ.push_back(8'h31 + 8'(i));
    end
    txQ.push_back(8'h26);
    txQ.push_back(8'h39);
    txQ.push_back(8'hF4);
    txQ.push_back(8'hCB);
    sendFrame(1'b0, txQ.size(), 1'b1);
    idle(3);
    checkFrame("check9", 1'b1, 1'b0, 1'b1, 13);

    // Truncated frame: new sof at byte 20, then a clean 64-byte frame back to back.
    clearMon();
    buildFrame(64, 8'h40, -1);
    sendFrame(1'b0, 20, 1'b0);
    buildFrame(64, 0, -1);
    sendFrame(1'b0, txQ.size(), 1'b1);
    idle(3);
    checkVal("trunc done_count", doneStep.size(), 2);
    if (doneStep.size() == 2) begin
      checkVal("trunc done_timing", doneStep[0], firstStep + 1);
      checkVal("trunc crc_err", doneCrc[0], 1);
      checkVal("trunc len_err", doneLenErr[0], 1);
      checkVal("trunc frame_len", doneFl[0], 20);
      checkVal("trunc next crc_err", doneCrc[1], 0);
      checkVal("trunc next len_err", doneLenErr[1], 0);
      checkVal("trunc next frame_len", doneFl[1], 64);
      checkVal("trunc next done_timing", doneStep[1], eofStep + 1);
    end
    checkVal("trunc out_count", rxQ.size(), 76);
    checkVal("trunc eof_count", eofIdx.size(), 1);
    if (eofIdx.size() == 1) checkVal("trunc eof_pos", eofIdx[0], 75);
    checkVal("trunc sof_count", sofIdx.size(), 2);
    if (sofIdx.size() == 2) checkVal("trunc sof2_pos", sofIdx[1], 16);
    if (rxQ.size() == 76) begin
      int bad = 0;
      for (int i = 0; i < 16; i++) if (rxQ[i] !== 8'h40 + 8'(i)) bad++;
      for (int i = 0; i < 60; i++) if (rxQ[16 + i] !== 8'(i)) bad++;
      checkVal("trunc out_data_errs", bad, 0);
    end

    // Asynchronous reset in the middle of a frame.
    clearMon();
    buildFrame(64, 0, -1);
    sendFrame(1'b0, 30, 1'b0);
    @(posedge clk);
    #2;
    checkVal("prereset out_valid", int'(out_valid), 1);
    checkVal("prereset out_data", int'(out_data), 25);
    rst = 1'b0;
    #1;
    checkVal("reset_async_outputs", outBus(), 0);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(2);
    checkVal("reset no_done", doneStep.size(), 0);
    clearMon();
    buildFrame(64, 0, -1);
    sendFrame(1'b0, txQ.size(), 1'b1);
    idle(3);
    checkFrame("after_reset", 1'b1, 1'b0, 1'b0, 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
